// File: rtl/d_branch_pkg.sv
// -----------------------------------------------------------------------------
// d_branch_pkg
// Definitions shared by the decode-stage branch resolution unit:
//   - bop_e     : branch-op encoding carried on i_con_bop
//   - cnt_t     : 2-bit saturating predictor counter and its reset value
//   - bht_index : PC -> counter-table index (word-aligned PC bits above [1:0])
//   - cnt_update: saturating increment/decrement of a counter
// -----------------------------------------------------------------------------
package d_branch_pkg;

    typedef enum logic [2:0] {
        BOP_NONE = 3'b000,
        BOP_BEQ  = 3'b001,
        BOP_BNE  = 3'b010,
        BOP_BLEZ = 3'b011,
        BOP_BGTZ = 3'b100,
        BOP_BLTZ = 3'b101,
        BOP_BGEZ = 3'b110
    } bop_e;

    // 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; MSB is the prediction.
    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_RESET = 2'b01;
    localparam cnt_t CNT_MAX   = 2'b11;
    localparam cnt_t CNT_MIN   = 2'b00;

    // Widest PC the index helper accepts; callers zero-extend into it.
    localparam int PC_MAX_W = 64;

    // Instructions are word aligned, so the index starts at pc[2].
    function automatic logic [31:0] bht_index(input logic [PC_MAX_W-1:0] pc,
                                              input int                  idx_w);
        return 32'((pc >> 2) & ((64'd1 << idx_w) - 64'd1));
    endfunction

    function automatic cnt_t cnt_update(input cnt_t cnt, input logic taken);
        if (taken) begin
            return (cnt == CNT_MAX) ? cnt : cnt + 2'd1;
        end
        return (cnt == CNT_MIN) ? cnt : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/d_branch_if.sv
// -----------------------------------------------------------------------------
// d_branch_if
// Bundle between fetch/decode/hazard logic and d_branch_resolve.
//   fetch : i_f_pc -> o_f_pred_taken
//   decode: i_d_valid, i_d_stall, i_d_pc, i_d_pred_taken, i_data_rs,
//           i_data_rt, i_con_bop -> o_con_ifbranch, o_mispredict, o_flush_q
//   stats : o_br_count, o_mis_count (only when D_BRANCH_STATS_EN is defined)
// Modports: master = pipeline side, slave = branch resolution unit.
// -----------------------------------------------------------------------------
interface d_branch_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
);
    logic [PC_W-1:0]   i_f_pc;
    logic              o_f_pred_taken;
    logic              i_d_valid;
    logic              i_d_stall;
    logic [PC_W-1:0]   i_d_pc;
    logic              i_d_pred_taken;
    logic [DATA_W-1:0] i_data_rs;
    logic [DATA_W-1:0] i_data_rt;
    logic [2:0]        i_con_bop;
    logic              o_con_ifbranch;
    logic              o_mispredict;
    logic              o_flush_q;
`ifdef D_BRANCH_STATS_EN
    logic [31:0]       o_br_count;
    logic [31:0]       o_mis_count;

    modport master (
        output i_f_pc, i_d_valid, i_d_stall, i_d_pc, i_d_pred_taken,
               i_data_rs, i_data_rt, i_con_bop,
        input  o_f_pred_taken, o_con_ifbranch, o_mispredict, o_flush_q,
               o_br_count, o_mis_count
    );
    modport slave (
        input  i_f_pc, i_d_valid, i_d_stall, i_d_pc, i_d_pred_taken,
               i_data_rs, i_data_rt, i_con_bop,
        output o_f_pred_taken, o_con_ifbranch, o_mispredict, o_flush_q,
               o_br_count, o_mis_count
    );
`else
    modport master (
        output i_f_pc, i_d_valid, i_d_stall, i_d_pc, i_d_pred_taken,
               i_data_rs, i_data_rt, i_con_bop,
        input  o_f_pred_taken, o_con_ifbranch, o_mispredict, o_flush_q
    );
    modport slave (
        input  i_f_pc, i_d_valid, i_d_stall, i_d_pc, i_d_pred_taken,
               i_data_rs, i_data_rt, i_con_bop,
        output o_f_pred_taken, o_con_ifbranch, o_mispredict, o_flush_q
    );
`endif
endinterface

// File: rtl/d_branch_cond.sv
// -----------------------------------------------------------------------------
// d_branch_cond
// Purely combinational MIPS branch condition evaluator.
//   i_bop     : branch op (bop_e encoding; 000/111 are not branches)
//   i_rs/i_rt : forwarded operands, signed two's complement
//   o_taken   : branch condition true (0 for non-branch codes)
//   o_is_br   : i_bop is one of the six branch codes
// -----------------------------------------------------------------------------
module d_branch_cond
    import d_branch_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        i_bop,
    input  logic [DATA_W-1:0] i_rs,
    input  logic [DATA_W-1:0] i_rt,
    output logic              o_taken,
    output logic              o_is_br
);
    logic w_rs_zero;
    logic w_rs_neg;

    assign w_rs_zero = (i_rs == '0);
    assign w_rs_neg  = i_rs[DATA_W-1];

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        o_taken = 1'b0;
        o_is_br = 1'b1;
        case (i_bop)
            BOP_BEQ:  o_taken = (i_rs == i_rt);
            BOP_BNE:  o_taken = (i_rs != i_rt);
            BOP_BLEZ: o_taken = w_rs_zero | w_rs_neg;
            BOP_BGTZ: o_taken = ~w_rs_zero & ~w_rs_neg;
            BOP_BLTZ: o_taken = w_rs_neg;
            BOP_BGEZ: o_taken = ~w_rs_neg;
            default:  o_is_br = 1'b0;
        endcase
    end

endmodule

// File: rtl/d_branch_resolve.sv
// -----------------------------------------------------------------------------
// d_branch_resolve
// Decode-stage branch resolution with a direct-mapped table of 2-bit
// saturating counters. Fetch reads the table combinationally; decode trains
// the entry of every resolved, non-stalled branch.
//   i_clk, i_rst : clock (rising edge), asynchronous active-high reset
//   bus (slave)  : fetch lookup, decode operands/op/prediction, resolution
//                  outputs and flush pulse (see d_branch_if)
// Optional feature: define D_BRANCH_STATS_EN to add saturating trained-branch
// (o_br_count) and trained-mispredict (o_mis_count) counters.
// -----------------------------------------------------------------------------
module d_branch_resolve
    import d_branch_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int BHT_DEPTH = 64
) (
    input logic     i_clk,
    input logic     i_rst,
    d_branch_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    cnt_t             r_bht [BHT_DEPTH];
    logic             r_flush_q;

    logic [PC_W-1:0]  w_f_pc;
    logic [PC_W-1:0]  w_d_pc;
    logic [IDX_W-1:0] w_f_idx;
    logic [IDX_W-1:0] w_d_idx;
    logic             w_taken;
    logic             w_is_br;
    logic             w_br;
    logic             w_mispredict;
    logic             w_train;

    assign w_f_pc  = bus.i_f_pc;
    assign w_d_pc  = bus.i_d_pc;
    assign w_f_idx = IDX_W'(bht_index(PC_MAX_W'(w_f_pc), IDX_W));
    assign w_d_idx = IDX_W'(bht_index(PC_MAX_W'(w_d_pc), IDX_W));

    d_branch_cond #(
        .DATA_W (DATA_W)
    ) u_cond (
        .i_bop   (bus.i_con_bop),
        .i_rs    (bus.i_data_rs),
        .i_rt    (bus.i_data_rt),
        .o_taken (w_taken),
        .o_is_br (w_is_br)
    );

    assign w_br         = bus.i_d_valid & w_is_br;
    // Mispredict is reported even while stalled so hazard logic can act on
    // it; only training is held off by the stall.
    assign w_mispredict = w_br & (w_taken != bus.i_d_pred_taken);
    assign w_train      = w_br & ~bus.i_d_stall;

    // NOTE: the counter table is made of flops that must start at weak-NT, so
    // it is reset like any other state rather than treated as an uninitialised
    // RAM. All sequential state uses non-blocking assignments so every flop
    // samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_bht[i] <= CNT_RESET;
            end
        end else if (w_train) begin
            r_bht[w_d_idx] <= cnt_update(r_bht[w_d_idx], w_taken);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_flush_q <= 1'b0;
        end else begin
            r_flush_q <= w_mispredict;
        end
    end

    // Lookup reads the registered table, so a same-cycle update to the same
    // index is not bypassed.
    assign bus.o_f_pred_taken = r_bht[w_f_idx][1] & ~i_rst;
    assign bus.o_con_ifbranch = w_taken;
    assign bus.o_mispredict   = w_mispredict;
    assign bus.o_flush_q      = r_flush_q;

`ifdef D_BRANCH_STATS_EN
    logic [31:0] r_br_count;
    logic [31:0] r_mis_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_br_count  <= '0;
            r_mis_count <= '0;
        end else if (w_train) begin
            if (r_br_count != 32'hFFFF_FFFF) begin
                r_br_count <= r_br_count + 32'd1;
            end
            if (w_mispredict && (r_mis_count != 32'hFFFF_FFFF)) begin
                r_mis_count <= r_mis_count + 32'd1;
            end
        end
    end

    assign bus.o_br_count  = r_br_count;
    assign bus.o_mis_count = r_mis_count;
`endif

endmodule

// File: tb/tb_d_branch_resolve.sv
// -----------------------------------------------------------------------------
// tb_d_branch_resolve
// Directed bench for d_branch_resolve. Inputs change on the falling edge;
// combinational outputs are sampled 1 ns later and registered outputs 1 ns
// after the rising edge.
// -----------------------------------------------------------------------------
module tb_d_branch_resolve;
    import d_branch_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    d_branch_if #(.DATA_W(32), .PC_W(32)) bus ();

    d_branch_resolve #(
        .DATA_W    (32),
        .PC_W      (32),
        .BHT_DEPTH (64)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic st, input logic [31:0] pc,
                         input logic [2:0] bop, input logic [31:0] rs,
                         input logic [31:0] rt, input logic pred);
        bus.i_d_valid      = v;
        bus.i_d_stall      = st;
        bus.i_d_pc         = pc;
        bus.i_con_bop      = bop;
        bus.i_data_rs      = rs;
        bus.i_data_rt      = rt;
        bus.i_d_pred_taken = pred;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.i_f_pc = 32'h40;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.o_f_pred_taken !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_pred_held: got %b exp 0", bus.o_f_pred_taken);
        end
        n_checks++;
        if (bus.o_flush_q !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flush: got %b exp 0", bus.o_flush_q);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            bus.i_f_pc = 32'(i * 4);
            #1;
            n_checks++;
            if (bus.o_f_pred_taken !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_pred idx %0d: got %b exp 0", i, bus.o_f_pred_taken);
            end
        end
    endtask

    task automatic test_beq_mispredict();
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h40, BOP_BEQ, 32'h1234, 32'h1234, 1'b0);
        bus.i_f_pc = 32'h100;
        #1;
        n_checks++;
        if (bus.o_con_ifbranch !== 1'b1) begin
            n_errors++;
            $display("FAIL beq_cond: got %b exp 1", bus.o_con_ifbranch);
        end
        n_checks++;
        if (bus.o_mispredict !== 1'b1) begin
            n_errors++;
            $display("FAIL beq_mispredict: got %b exp 1", bus.o_mispredict);
        end
        @(posedge clk);
        #1;
        idle();
        n_checks++;
        if (bus.o_flush_q !== 1'b1) begin
            n_errors++;
            $display("FAIL beq_flush_q: got %b exp 1", bus.o_flush_q);
        end
        bus.i_f_pc = 32'h40;
        #1;
        n_checks++;
        if (bus.o_f_pred_taken !== 1'b1) begin
            n_errors++;
            $display("FAIL beq_trained_pred: got %b exp 1", bus.o_f_pred_taken);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.o_flush_q !== 1'b0) begin
            n_errors++;
            $display("FAIL beq_flush_drop: got %b exp 0", bus.o_flush_q);
        end
    endtask

    task automatic test_same_index();
        // idx 32: taken bne trains 01 -> 10, then not-taken bne 10 -> 01
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h80, BOP_BNE, 32'h1, 32'h2, 1'b0);
        bus.i_f_pc = 32'h80;
        #1;
        n_checks++;
        if (bus.o_f_pred_taken !== 1'b0) begin
            n_errors++;
            $display("FAIL same_idx_old_01: got %b exp 0", bus.o_f_pred_taken);
        end
        @(posedge clk);
        #1;
        idle();
        n_checks++;
        if (bus.o_f_pred_taken !== 1'b1) begin
            n_errors++;
            $display("FAIL same_idx_new_10: got %b exp 1", bus.o_f_pred_taken);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h80, BOP_BNE, 32'h7, 32'h7, 1'b1);
        #1;
        n_checks++;
        if (bus.o_f_pred_taken !== 1'b1) begin
            n_errors++;
            $display("FAIL same_idx_old_10: got %b exp 1", bus.o_f_pred_taken);
        end
        @(posedge clk);
        #1;
        idle();
        n_checks++;
        if (bus.o_f_pred_taken !== 1'b0) begin
            n_errors++;
            $display("FAIL same_idx_new_01: got %b exp 0", bus.o_f_pred_taken);
        end
    endtask

    task automatic test_saturation();
        // idx 2: 01 -> 10 -> 11 -> 11 -> 11 (taken), then 10 -> 01 (not taken)
        logic        exp_p [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] rs;
        logic        tk;
        bus.i_f_pc = 32'h8;
        for (int i = 0; i < 6; i++) begin
            tk = (i < 4);
            rs = tk ? 32'h0 : 32'h8000_0000;
            @(negedge clk);
            drive(1'b1, 1'b0, 32'h8, BOP_BGEZ, rs, 32'h0, tk);
            #1;
            n_checks++;
            if (bus.o_con_ifbranch !== tk) begin
                n_errors++;
                $display("FAIL sat_cond step %0d: got %b exp %b", i, bus.o_con_ifbranch, tk);
            end
            @(posedge clk);
            #1;
            idle();
            n_checks++;
            if (bus.o_f_pred_taken !== exp_p[i]) begin
                n_errors++;
                $display("FAIL sat_pred step %0d: got %b exp %b", i, bus.o_f_pred_taken, exp_p[i]);
            end
        end
    endtask

    task automatic test_signed_bounds();
        logic [2:0]  ops  [3]  = '{BOP_BLEZ, BOP_BGTZ, BOP_BLTZ};
        logic [31:0] vals [4]  = '{32'h0, 32'h1, 32'h8000_0000, 32'h7FFF_FFFF};
        logic        exp  [12] = '{1'b1, 1'b0, 1'b1, 1'b0,
                                   1'b0, 1'b1, 1'b0, 1'b1,
                                   1'b0, 1'b0, 1'b1, 1'b0};
        for (int o = 0; o < 3; o++) begin
            for (int v = 0; v < 4; v++) begin
                @(negedge clk);
                // stalled so the table is left alone; pred 0 makes mispredict == outcome
                drive(1'b1, 1'b1, 32'h100, ops[o], vals[v], 32'h0, 1'b0);
                #1;
                n_checks++;
                if (bus.o_con_ifbranch !== exp[o*4+v]) begin
                    n_errors++;
                    $display("FAIL signed op %0d rs %h: got %b exp %b",
                             ops[o], vals[v], bus.o_con_ifbranch, exp[o*4+v]);
                end
                n_checks++;
                if (bus.o_mispredict !== exp[o*4+v]) begin
                    n_errors++;
                    $display("FAIL signed_mis op %0d rs %h: got %b exp %b",
                             ops[o], vals[v], bus.o_mispredict, exp[o*4+v]);
                end
            end
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_no_train();
        // idx 3 set to weak-T; every blocked case has a not-taken outcome, so
        // any wrongful training would drop the prediction to 0.
        logic        v    [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic        st   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [2:0]  bop  [4] = '{BOP_BNE, BOP_BEQ, 3'b000, 3'b111};
        logic [31:0] rt   [4] = '{32'h7, 32'h4, 32'h9, 32'h9};
        logic [31:0] rs   [4] = '{32'h7, 32'h3, 32'h9, 32'h9};
        logic        e_mis[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        @(negedge clk);
        drive(1'b1, 1'b0, 32'hC, BOP_BEQ, 32'h5, 32'h5, 1'b1);
        @(posedge clk);
        #1;
        idle();
        bus.i_f_pc = 32'hC;
        #1;
        n_checks++;
        if (bus.o_f_pred_taken !== 1'b1) begin
            n_errors++;
            $display("FAIL notrain_setup: got %b exp 1", bus.o_f_pred_taken);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(v[i], st[i], 32'hC, bop[i], rs[i], rt[i], 1'b1);
            #1;
            n_checks++;
            if (bus.o_con_ifbranch !== 1'b0) begin
                n_errors++;
                $display("FAIL notrain_cond case %0d: got %b exp 0", i, bus.o_con_ifbranch);
            end
            n_checks++;
            if (bus.o_mispredict !== e_mis[i]) begin
                n_errors++;
                $display("FAIL notrain_mis case %0d: got %b exp %b", i, bus.o_mispredict, e_mis[i]);
            end
            @(posedge clk);
            #1;
            idle();
            n_checks++;
            if (bus.o_flush_q !== e_mis[i]) begin
                n_errors++;
                $display("FAIL notrain_flush case %0d: got %b exp %b", i, bus.o_flush_q, e_mis[i]);
            end
            n_checks++;
            if (bus.o_f_pred_taken !== 1'b1) begin
                n_errors++;
                $display("FAIL notrain_pred case %0d: got %b exp 1", i, bus.o_f_pred_taken);
            end
        end
    endtask

    task automatic test_mid_reset();
        bus.i_f_pc = 32'h40;
        #1;
        n_checks++;
        if (bus.o_f_pred_taken !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_pre: got %b exp 1", bus.o_f_pred_taken);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h40, BOP_BEQ, 32'h1, 32'h1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.o_f_pred_taken !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_pred: got %b exp 0", bus.o_f_pred_taken);
        end
        n_checks++;
        if (bus.o_con_ifbranch !== 1'b1 || bus.o_mispredict !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_comb: got cond %b mis %b exp 1 1",
                     bus.o_con_ifbranch, bus.o_mispredict);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.o_flush_q !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_flush: got %b exp 0", bus.o_flush_q);
        end
        @(negedge clk);
        idle();
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.o_f_pred_taken !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_idx16: got %b exp 0", bus.o_f_pred_taken);
        end
        bus.i_f_pc = 32'hC;
        #1;
        n_checks++;
        if (bus.o_f_pred_taken !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_idx3: got %b exp 0", bus.o_f_pred_taken);
        end
    endtask

    task automatic test_back_to_back();
        // idx 4 taken (mis), idx 5 not taken (ok), idx 6 taken (mis), no idle between
        logic [31:0] pc   [3] = '{32'h10, 32'h14, 32'h18};
        logic [2:0]  bop  [3] = '{BOP_BEQ, BOP_BNE, BOP_BLTZ};
        logic [31:0] rs   [3] = '{32'h3, 32'h3, 32'hFFFF_FFFF};
        logic        e_fq [3] = '{1'b1, 1'b0, 1'b1};
        logic        e_pr [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, pc[i], bop[i], rs[i], 32'h3, 1'b0);
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.o_flush_q !== e_fq[i]) begin
                n_errors++;
                $display("FAIL b2b_flush step %0d: got %b exp %b", i, bus.o_flush_q, e_fq[i]);
            end
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            bus.i_f_pc = 32'h10 + 32'(i * 4);
            #1;
            n_checks++;
            if (bus.o_f_pred_taken !== e_pr[i]) begin
                n_errors++;
                $display("FAIL b2b_pred idx %0d: got %b exp %b", 4 + i, bus.o_f_pred_taken, e_pr[i]);
            end
        end
    endtask

`ifdef D_BRANCH_STATS_EN
    task automatic test_stats();
        logic        v    [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        st   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  bop  [6] = '{BOP_BEQ, BOP_BNE, BOP_BGTZ, BOP_BLTZ, BOP_BLTZ, BOP_BGEZ};
        logic [31:0] rs   [6] = '{32'h1, 32'h1, 32'h5, 32'h0, 32'h8000_0000, 32'h0};
        logic        pred [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.o_br_count !== 32'd0 || bus.o_mis_count !== 32'd0) begin
            n_errors++;
            $display("FAIL stats_reset: got %0d/%0d exp 0/0", bus.o_br_count, bus.o_mis_count);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(v[i], st[i], 32'h20 + 32'(i * 4), bop[i], rs[i], 32'h1, pred[i]);
            @(posedge clk);
            #1;
            idle();
        end
        n_checks++;
        if (bus.o_br_count !== 32'd5) begin
            n_errors++;
            $display("FAIL stats_br: got %0d exp 5", bus.o_br_count);
        end
        n_checks++;
        if (bus.o_mis_count !== 32'd2) begin
            n_errors++;
            $display("FAIL stats_mis: got %0d exp 2", bus.o_mis_count);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        idle();
        bus.i_f_pc = 32'h0;
        test_reset();
        test_beq_mispredict();
        test_same_index();
        test_saturation();
        test_signed_bounds();
        test_no_train();
        test_mid_reset();
        test_back_to_back();
`ifdef D_BRANCH_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/d_branch_resolve.md
# d_branch_resolve

Parametrised decode-stage branch resolution unit: evaluates the MIPS branch condition (beq/bne/blez/bgtz/bltz/bgez) on forwarded register operands, compares it against the prediction made at fetch, and owns a direct-mapped table of 2-bit saturating counters. Fetch reads the table combinationally. Decode trains it on every resolved branch. It replaces the stateless decode comparator and sits between the register-file/forwarding muxes and the hazard/flush logic.

## Interface
- DATA_W, 32, operand width
- PC_W, 32, program counter width
- BHT_DEPTH, 64, counter-table entries (power of 2, ≥2); IDX_W = log2(BHT_DEPTH)
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_f_pc  in  PC_W  fetch PC for prediction lookup
- o_f_pred_taken  out  1  prediction for i_f_pc
- i_d_valid  in  1  decode stage holds a valid instruction
- i_d_stall  in  1  decode stalled; suppresses training
- i_d_pc  in  PC_W  PC of decode instruction
- i_d_pred_taken  in  1  prediction carried with the instruction from fetch
- i_data_rs  in  DATA_W  rs operand (forwarded)
- i_data_rt  in  DATA_W  rt operand (forwarded)
- i_con_bop  in  3  branch op: 001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110 bgez, 000/111 not a branch
- o_con_ifbranch  out  1  branch condition true
- o_mispredict  out  1  resolved outcome differs from i_d_pred_taken
- o_flush_q  out  1  o_mispredict registered (one-cycle flush pulse)

## Operation
- Index: idx = pc[IDX_W+1:2] for both i_f_pc and i_d_pc.
- Condition (signed, sign bit = operand[DATA_W-1]): beq rs==rt; bne rs!=rt; blez rs==0 or sign; bgtz rs!=0 and not sign; bltz sign; bgez not sign. Codes 000/111 -> o_con_ifbranch = 0.
- br = i_d_valid and i_con_bop in 001..110.
- o_mispredict = br and (o_con_ifbranch != i_d_pred_taken). o_mispredict is asserted even when i_d_stall is high.
- o_f_pred_taken = MSB of counter[idx(i_f_pc)].
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Training, when br and not i_d_stall: if taken, increment the counter, saturating at 11. If not taken, decrement it, saturating at 00.
- Only one entry updates per cycle.

## Timing
- Condition, o_con_ifbranch, o_mispredict, o_f_pred_taken: combinational, zero latency.
- Counter update is visible at the clock edge following the training cycle.
- Same-cycle lookup and update to the same index: lookup returns the pre-update value. No bypass.
- o_flush_q = o_mispredict sampled at each rising edge; 1-cycle latency. It is not masked by stall.
- Reset (asserted any time, including mid-branch): all counters -> 01; o_flush_q -> 0; stats counters -> 0.
- While reset is held, o_f_pred_taken = 0. Combinational outputs follow their inputs throughout reset.
- Training blocked during reset.

## Configuration
- D_BRANCH_STATS_EN defined:
  - adds outputs o_br_count [31:0] (trained branches) and o_mis_count [31:0] (trained mispredicts);
  - both increment under the same gate as training;
  - both saturate at 32'hFFFF_FFFF.
- D_BRANCH_STATS_EN undefined: those ports and their counters are absent. All other behaviour is identical.

## Structure
- Shared package d_branch_pkg holds:
  - typedef enum for the bop codes (BOP_NONE, BOP_BEQ, BOP_BNE, BOP_BLEZ, BOP_BGTZ, BOP_BLTZ, BOP_BGEZ);
  - typedef for the 2-bit counter state plus CNT_RESET = 2'b01;
  - index-extraction function.
- One sub-module, d_branch_cond: purely combinational condition evaluator (DATA_W-parametrised).
- The table, training, flush register and stats live in the top module.

## Test plan
- Reset: i_rst=1 mid-run, then release; every index reads counter 01 -> o_f_pred_taken=0, o_flush_q=0.
- beq, rs=rt=32'h1234, pred=0, pc=0x40 -> o_con_ifbranch=1, o_mispredict=1, o_flush_q=1 next cycle; counter[16] 01->10, so fetch pc=0x40 then predicts taken.
- Saturation: four taken bgez at pc=0x8 (rs=0) -> counter stays 11; two not-taken -> 01.
- Signed bounds, blez/bgtz/bltz with rs = 0, 1, 32'h8000_0000, 32'h7FFF_FFFF -> outcomes 1/0/1/0, 0/1/0/1, 0/0/1/0 respectively.
- Stall/invalid/bop 000/111: o_con_ifbranch per rules, no counter change; stalled mispredict still drives o_mispredict=1.
- Same-index lookup during update returns the old value. With D_BRANCH_STATS_EN: 5 branches, 2 mispredicted -> o_br_count=5, o_mis_count=2.
